// File: rtl/if_id_stage.sv
// if_id_stage: fetch-to-decode skid buffer (2 entries) with valid/ready toward decode.
// Latency: an entry pushed at edge N is visible on id_* right after edge N; there is no comb path from if_* to id_*.
// Backpressure: in_ready drops only when both slots are full, and it is decoded from state alone.
//
// Ports:
//   clk, reset (async, active-low)
//   if_instr/if_pc/if_valid -> in_ready    : fetch side; the PC stage holds pc_next while in_ready=0
//   flush                                  : taken branch/jump, drops everything
//   id_instr/id_pc/id_pc_plus4/id_misaligned/id_valid <- id_ready : decode side
//   bubble_cnt/stall_cnt                   : only present when IFID_PERF_CNT_EN is defined
module if_id_stage #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            if_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            id_misaligned,
  output logic            id_valid,
`ifdef IFID_PERF_CNT_EN
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     stall_cnt,
`endif
  input  logic            id_ready
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state, state_nxt;

  // Shift structure: slot 0 is always the head, slot 1 the entry behind it.
  logic [XLEN-1:0] head_instr, head_pc;
  logic [XLEN-1:0] tail_instr, tail_pc;

  logic push, pop;
  logic load_head, load_tail, shift_up;

  assign in_ready = (state != FULL);
  assign id_valid = (state != EMPTY);
  assign push     = if_valid & in_ready & ~flush;
  assign pop      = id_valid & id_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    load_tail = 1'b0;
    shift_up  = 1'b0;
    if (flush) begin
      // Flush wins over everything; the slots keep their data so id_pc holds its last value.
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state_nxt = ONE;
            load_head = 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_nxt = FULL;
            load_tail = 1'b1;
          end else if (pop && !push) begin
            state_nxt = EMPTY;
          end else if (push && pop) begin
            // Head leaves and the incoming word takes its place in the same cycle.
            load_head = 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            state_nxt = ONE;
            shift_up  = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_instr <= NOP_INSTR;
      head_pc    <= '0;
      tail_instr <= NOP_INSTR;
      tail_pc    <= '0;
    end else begin
      if (load_head) begin
        head_instr <= if_instr;
        head_pc    <= if_pc;
      end else if (shift_up) begin
        head_instr <= tail_instr;
        head_pc    <= tail_pc;
      end
      if (load_tail) begin
        tail_instr <= if_instr;
        tail_pc    <= if_pc;
      end
    end
  end

  assign id_instr      = id_valid ? head_instr : NOP_INSTR;
  assign id_pc         = head_pc;
  assign id_pc_plus4   = head_pc + XLEN'(4);
  assign id_misaligned = |head_pc[1:0];

`ifdef IFID_PERF_CNT_EN
  // Saturating event counters; flush deliberately leaves them alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (!id_valid && id_ready && (bubble_cnt != 32'hFFFFFFFF))
        bubble_cnt <= bubble_cnt + 32'd1;
      if (if_valid && !in_ready && (stall_cnt != 32'hFFFFFFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] IA = 32'hAAAA0001, IB = 32'hBBBB0002, IC = 32'hCCCC0003;

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] if_instr, if_pc;
  logic            if_valid, in_ready, flush;
  logic [XLEN-1:0] id_instr, id_pc, id_pc_plus4;
  logic            id_misaligned, id_valid, id_ready;
`ifdef IFID_PERF_CNT_EN
  logic [31:0]     bubble_cnt, stall_cnt;
`endif

  int passed = 0;
  int total  = 0;

  if_id_stage #(.XLEN(XLEN), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid), .in_ready(in_ready),
    .flush(flush),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_misaligned(id_misaligned), .id_valid(id_valid),
`ifdef IFID_PERF_CNT_EN
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt),
`endif
    .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    if_valid = v;
    if_pc    = pc;
    if_instr = ins;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; id_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #3;
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_instr", id_instr, NOP);
    check("rst_pc", id_pc, 32'd0);
    check("rst_pc4", id_pc_plus4, 32'd4);
    check("rst_mis", {31'd0, id_misaligned}, 32'd0);
    check("rst_inrdy", {31'd0, in_ready}, 32'd1);
    reset = 1'b1;
    step();
    check("post_rel_valid", {31'd0, id_valid}, 32'd0);

    // Streaming with decode always ready
    id_ready = 1'b1;
    drive(1'b1, 32'h0, IA); step();
    check("s0_valid", {31'd0, id_valid}, 32'd1);
    check("s0_pc", id_pc, 32'h0);
    check("s0_pc4", id_pc_plus4, 32'h4);
    check("s0_instr", id_instr, IA);
    check("s0_inrdy", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h4, IB); step();
    check("s1_pc", id_pc, 32'h4);
    check("s1_pc4", id_pc_plus4, 32'h8);
    check("s1_instr", id_instr, IB);
    check("s1_inrdy", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h8, IC); step();
    check("s2_pc", id_pc, 32'h8);
    check("s2_pc4", id_pc_plus4, 32'hC);
    check("s2_instr", id_instr, IC);
    drive(1'b0, 32'h0, 32'h0); step();
    check("s3_valid", {31'd0, id_valid}, 32'd0);
    check("s3_instr_nop", id_instr, NOP);
    check("s3_pc_hold", id_pc, 32'h8);

    // Back-pressure
    id_ready = 1'b0;
    drive(1'b1, 32'h10, IA); step();
    check("bp0_pc", id_pc, 32'h10);
    check("bp0_inrdy", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h14, IB); step();
    check("bp1_inrdy", {31'd0, in_ready}, 32'd0);
    check("bp1_pc", id_pc, 32'h10);
    drive(1'b1, 32'h18, IC); step();
    check("bp2_inrdy", {31'd0, in_ready}, 32'd0);
    check("bp2_pc_hold", id_pc, 32'h10);
    check("bp2_instr_hold", id_instr, IA);
    drive(1'b0, 32'h0, 32'h0); id_ready = 1'b1; step();
    check("bp3_pc", id_pc, 32'h14);
    check("bp3_instr", id_instr, IB);
    check("bp3_inrdy", {31'd0, in_ready}, 32'd1);
    step();
    check("bp4_valid", {31'd0, id_valid}, 32'd0);

    // Flush priority from FULL
    id_ready = 1'b0;
    drive(1'b1, 32'h20, IA); step();
    drive(1'b1, 32'h24, IB); step();
    check("fl_full", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; id_ready = 1'b1; drive(1'b1, 32'h40, IC); step();
    check("fl_valid", {31'd0, id_valid}, 32'd0);
    check("fl_inrdy", {31'd0, in_ready}, 32'd1);
    flush = 1'b0; drive(1'b0, 32'h0, 32'h0); step();
    check("fl_valid2", {31'd0, id_valid}, 32'd0);
    check("fl_pc_not40", id_pc, 32'h20);

    // Boundary PCs
    id_ready = 1'b0;
    drive(1'b1, 32'hFFFFFFFC, IA); step();
    check("wrap_pc4", id_pc_plus4, 32'h0);
    check("wrap_mis", {31'd0, id_misaligned}, 32'd0);
    id_ready = 1'b1; drive(1'b1, 32'h6, IB); step();
    check("mis_pc", id_pc, 32'h6);
    check("mis_flag", {31'd0, id_misaligned}, 32'd1);
    check("mis_pc4", id_pc_plus4, 32'hA);
    drive(1'b0, 32'h0, 32'h0); step();

    // Asynchronous reset with two entries held
    id_ready = 1'b0;
    drive(1'b1, 32'h30, IA); step();
    drive(1'b1, 32'h34, IB); step();
    drive(1'b0, 32'h0, 32'h0);
    check("ar_full", {31'd0, in_ready}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("ar_valid", {31'd0, id_valid}, 32'd0);
    check("ar_instr", id_instr, NOP);
    check("ar_inrdy", {31'd0, in_ready}, 32'd1);
    check("ar_pc", id_pc, 32'h0);
    #1 reset = 1'b1;
    step();
    check("ar_after_valid", {31'd0, id_valid}, 32'd0);

`ifdef IFID_PERF_CNT_EN
    check("pc_stall0", stall_cnt, 32'd0);
    id_ready = 1'b0;
    drive(1'b1, 32'h50, IA); step();
    drive(1'b1, 32'h54, IB); step();
    drive(1'b1, 32'h58, IC);
    step(); step(); step();
    check("pc_stall3", stall_cnt, 32'd3);
    drive(1'b0, 32'h0, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
